// File: rtl/channel_reg_bank_pkg.sv
// Address map, CONTROL bit positions and shared types for the ADC channel register bank.
package channel_reg_bank_pkg;

    localparam logic [17:0] OFS_ID      = 18'd0;
    localparam logic [17:0] OFS_CONTROL = 18'd1;
    localparam logic [17:0] OFS_STATUS  = 18'd2;
    localparam logic [17:0] OFS_PENDING = 18'd3;
    localparam logic [17:0] OFS_SHADOW  = 18'd16;
    localparam logic [17:0] OFS_ACTIVE  = 18'd144;

    localparam int CTRL_PULSE_BIT  = 0;
    localparam int CTRL_COMMIT_BIT = 1;

    typedef enum logic {
        PS_IDLE  = 1'b0,
        PS_PULSE = 1'b1
    } pulse_state_e;

    // Each channel owns a CONFIG/THRESHOLD word pair inside a region.
    function automatic logic [17:0] ch_addr(input logic [17:0] region, input int k, input logic is_thr);
        return region + 18'(2 * k) + {17'h0, is_thr};
    endfunction

endpackage

// File: rtl/channel_reg_bank_pulse.sv
// reg_pulse_stretch: holds an output pulse for PULSE_LEN cycles; a new start restarts the count.
module reg_pulse_stretch
    import channel_reg_bank_pkg::*;
#(
    parameter int PULSE_LEN = 8
) (
    input  logic         CLK,
    input  logic         RSTb,
    input  logic         start,
    output pulse_state_e state
);

    pulse_state_e state_nxt;
    logic [7:0]   cnt;
    logic [7:0]   cnt_nxt;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state <= PS_IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts pulse cycles already shown, so the last pulse cycle has cnt == PULSE_LEN.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            PS_IDLE: begin
                if (start) begin
                    state_nxt = PS_PULSE;
                    cnt_nxt   = 8'd1;
                end
            end
            PS_PULSE: begin
                if (start) begin
                    cnt_nxt = 8'd1;
                end else if (cnt == 8'(PULSE_LEN)) begin
                    state_nxt = PS_IDLE;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = PS_IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

endmodule

// File: rtl/channel_reg_bank.sv
// Per-channel CONFIG/THRESHOLD shadow+active register bank with ID, CONTROL, sticky STATUS and PENDING.
module channel_reg_bank
    import channel_reg_bank_pkg::*;
#(
    parameter int          N_CH       = 16,
    parameter logic [17:0] BASE_A     = 18'h0,
    parameter logic [31:0] ID_WORD    = 32'h04_00_00_05,
    parameter logic [31:0] DUMMY_WORD = 32'hDEAD_BEEF,
    parameter int          PULSE_LEN  = 8
) (
    input  logic                 CLK,
    input  logic                 RSTb,
    input  logic [17:0]          ADDR,
    input  logic [31:0]          DATA_IN,
    output logic [31:0]          DATA_OUT,
    input  logic                 CEb,
    input  logic                 WEb,
    input  logic                 REb,
    output logic                 ACK,
    input  logic                 SYNC_LOAD,
    input  logic [N_CH-1:0]      STATUS_IN,
    output logic                 USER_RESET,
    output logic [16*N_CH-1:0]   CH_CONFIG,
    output logic [12*N_CH-1:0]   CH_THRESHOLD
);

    // Bus protocol: an access is accepted on the first cycle its strobe combination is seen
    // (write: CEb=0,WEb=0; read: CEb=0,REb=0,WEb=1); ACK and read DATA_OUT follow one cycle later.
    logic        wr_strobe, rd_strobe, wr_hist, rd_hist, wr_acc, rd_acc;
    logic [17:0] off;
    logic        ctrl_wr, pulse_start, commit, shadow_wr;
    logic [N_CH-1:0] cfg_we, thr_we, ch_hit;
    logic [31:0] ch_rdata [N_CH];
    logic [31:0] rd_data;
    logic [N_CH-1:0] status_q, status_clr;
    logic [63:0] status_ext, din_ext;
    logic        pend_q;
    logic        unused_ok;
    pulse_state_e pulse_state;

    assign wr_strobe = ~CEb & ~WEb;
    assign rd_strobe = ~CEb & ~REb & WEb;
    assign wr_acc    = wr_strobe & ~wr_hist;
    assign rd_acc    = rd_strobe & ~rd_hist;
    assign off       = ADDR - BASE_A;

    assign ctrl_wr     = wr_acc && (off == OFS_CONTROL);
    assign pulse_start = ctrl_wr & DATA_IN[CTRL_PULSE_BIT];
    assign commit      = SYNC_LOAD | (ctrl_wr & DATA_IN[CTRL_COMMIT_BIT]);
    assign shadow_wr   = |{cfg_we, thr_we};

    assign status_ext = 64'(status_q);
    assign din_ext    = {32'h0, DATA_IN};
    assign status_clr = (wr_acc && (off == OFS_STATUS)) ? din_ext[N_CH-1:0] : '0;
    assign unused_ok  = ^{DATA_IN, din_ext, status_ext};

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        localparam logic [17:0] A_CS = ch_addr(OFS_SHADOW, k, 1'b0);
        localparam logic [17:0] A_TS = ch_addr(OFS_SHADOW, k, 1'b1);
        localparam logic [17:0] A_CA = ch_addr(OFS_ACTIVE, k, 1'b0);
        localparam logic [17:0] A_TA = ch_addr(OFS_ACTIVE, k, 1'b1);

        logic [15:0] cfg_sh, cfg_act;
        logic [11:0] thr_sh, thr_act;

        assign cfg_we[k] = wr_acc && (off == A_CS);
        assign thr_we[k] = wr_acc && (off == A_TS);

        // Commit samples the shadow before a same-cycle shadow write lands.
        always_ff @(posedge CLK or negedge RSTb) begin
            if (!RSTb) begin
                cfg_sh  <= 16'h0;
                thr_sh  <= 12'h0;
                cfg_act <= 16'h0;
                thr_act <= 12'h0;
            end else begin
                if (cfg_we[k]) cfg_sh <= DATA_IN[15:0];
                if (thr_we[k]) thr_sh <= DATA_IN[11:0];
                if (commit) begin
                    cfg_act <= cfg_sh;
                    thr_act <= thr_sh;
                end
            end
        end

        assign CH_CONFIG[16*k +: 16]    = cfg_act;
        assign CH_THRESHOLD[12*k +: 12] = thr_act;
        assign ch_hit[k]   = (off == A_CS) | (off == A_TS) | (off == A_CA) | (off == A_TA);
        assign ch_rdata[k] = (off == A_CS) ? {16'h0, cfg_sh} :
                             (off == A_TS) ? {20'h0, thr_sh} :
                             (off == A_CA) ? {16'h0, cfg_act} : {20'h0, thr_act};
    end

    always_comb begin
        rd_data = DUMMY_WORD;
        case (off)
            OFS_ID:      rd_data = ID_WORD;
            OFS_CONTROL: rd_data = 32'h0;
            OFS_STATUS:  rd_data = status_ext[31:0];
            OFS_PENDING: rd_data = {31'h0, pend_q};
            default: begin
                for (int k = 0; k < N_CH; k++) begin
                    if (ch_hit[k]) rd_data = ch_rdata[k];
                end
            end
        endcase
    end

    // Edge history resets to "asserted" so a strobe held across reset release is ignored.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            wr_hist  <= 1'b1;
            rd_hist  <= 1'b1;
            ACK      <= 1'b0;
            DATA_OUT <= 32'h0;
            status_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            wr_hist  <= wr_strobe;
            rd_hist  <= rd_strobe;
            ACK      <= wr_acc | rd_acc;
            if (rd_acc) DATA_OUT <= rd_data;
            status_q <= (status_q & ~status_clr) | STATUS_IN;
            if (shadow_wr)   pend_q <= 1'b1;
            else if (commit) pend_q <= 1'b0;
        end
    end

    reg_pulse_stretch #(
        .PULSE_LEN(PULSE_LEN)
    ) u_pulse (
        .CLK  (CLK),
        .RSTb (RSTb),
        .start(pulse_start),
        .state(pulse_state)
    );

    assign USER_RESET = (pulse_state == PS_PULSE);

endmodule

// File: tb/tb_channel_reg_bank.sv
// Directed plus randomized bench for channel_reg_bank against an array-based register model.
module tb_channel_reg_bank;

    localparam int          N_CH   = 16;
    localparam logic [17:0] BASE_A = 18'h1000;
    localparam logic [31:0] ID_W   = 32'h04_00_00_05;
    localparam logic [31:0] DUMMY  = 32'hDEAD_BEEF;
    localparam int          PLEN   = 8;

    logic                CLK, RSTb;
    logic [17:0]         ADDR;
    logic [31:0]         DATA_IN, DATA_OUT;
    logic                CEb, WEb, REb, ACK, SYNC_LOAD, USER_RESET;
    logic [N_CH-1:0]     STATUS_IN;
    logic [16*N_CH-1:0]  CH_CONFIG;
    logic [12*N_CH-1:0]  CH_THRESHOLD;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    logic [15:0] m_cfg_sh [N_CH];
    logic [15:0] m_cfg_act[N_CH];
    logic [11:0] m_thr_sh [N_CH];
    logic [11:0] m_thr_act[N_CH];
    logic [15:0] m_status;
    logic        m_pend;

    channel_reg_bank #(
        .N_CH(N_CH), .BASE_A(BASE_A), .ID_WORD(ID_W), .DUMMY_WORD(DUMMY), .PULSE_LEN(PLEN)
    ) dut (
        .CLK(CLK), .RSTb(RSTb), .ADDR(ADDR), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
        .CEb(CEb), .WEb(WEb), .REb(REb), .ACK(ACK), .SYNC_LOAD(SYNC_LOAD),
        .STATUS_IN(STATUS_IN), .USER_RESET(USER_RESET), .CH_CONFIG(CH_CONFIG),
        .CH_THRESHOLD(CH_THRESHOLD)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model
    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_cfg_sh[k] = '0; m_cfg_act[k] = '0; m_thr_sh[k] = '0; m_thr_act[k] = '0;
        end
        m_status = '0;
        m_pend   = 1'b0;
    endtask

    task automatic model_commit();
        for (int k = 0; k < N_CH; k++) begin
            m_cfg_act[k] = m_cfg_sh[k];
            m_thr_act[k] = m_thr_sh[k];
        end
        m_pend = 1'b0;
    endtask

    task automatic model_write(input int off, input logic [31:0] d);
        if (off == 1 && d[1]) model_commit();
        if (off == 2) m_status = m_status & ~d[15:0];
        if (off >= 16 && off < 16 + 2 * N_CH) begin
            if (off % 2 == 0) m_cfg_sh[(off - 16) / 2] = d[15:0];
            else              m_thr_sh[(off - 16) / 2] = d[11:0];
            m_pend = 1'b1;
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        if (off == 0) return ID_W;
        if (off == 1) return 32'h0;
        if (off == 2) return {16'h0, m_status};
        if (off == 3) return {31'h0, m_pend};
        if (off >= 16 && off < 16 + 2 * N_CH)
            return (off % 2 == 0) ? {16'h0, m_cfg_sh[(off - 16) / 2]} : {20'h0, m_thr_sh[(off - 16) / 2]};
        if (off >= 144 && off < 144 + 2 * N_CH)
            return (off % 2 == 0) ? {16'h0, m_cfg_act[(off - 144) / 2]} : {20'h0, m_thr_act[(off - 144) / 2]};
        return DUMMY;
    endfunction

    function automatic logic [255:0] exp_cfg_vec();
        logic [255:0] v = '0;
        for (int k = 0; k < N_CH; k++) v[16*k +: 16] = m_cfg_act[k];
        return v;
    endfunction

    function automatic logic [255:0] exp_thr_vec();
        logic [255:0] v = '0;
        for (int k = 0; k < N_CH; k++) v[12*k +: 12] = m_thr_act[k];
        return v;
    endfunction

    // driver tasks
    task automatic bus_write(input int off, input logic [31:0] d);
        @(negedge CLK);
        ADDR = BASE_A + 18'(off); DATA_IN = d; CEb = 1'b0; WEb = 1'b0;
        @(negedge CLK);
        check("wr_ack", ACK, 1);
        CEb = 1'b1; WEb = 1'b1;
        model_write(off, d);
    endtask

    task automatic read_check(input int off, input string tag);
        logic [31:0] e;
        exp_q.push_back(model_read(off));
        @(negedge CLK);
        ADDR = BASE_A + 18'(off); CEb = 1'b0; REb = 1'b0; WEb = 1'b1;
        #1 check("rd_ack_early", ACK, 0);
        @(negedge CLK);
        e = exp_q.pop_front();
        check("rd_ack", ACK, 1);
        check(tag, DATA_OUT, e);
        CEb = 1'b1; REb = 1'b1;
        @(negedge CLK);
        check("rd_ack_once", ACK, 0);
        check("rd_hold", DATA_OUT, e);
    endtask

    task automatic check_active(input string tag);
        check({tag, "_cfg"}, CH_CONFIG, exp_cfg_vec());
        check({tag, "_thr"}, CH_THRESHOLD, exp_thr_vec());
    endtask

    initial begin
        RSTb = 1'b0; CEb = 1'b1; WEb = 1'b1; REb = 1'b1; SYNC_LOAD = 1'b0;
        ADDR = '0; DATA_IN = '0; STATUS_IN = '0;
        model_reset();
        repeat (3) @(negedge CLK);
        check("rst_dout", DATA_OUT, 0);
        check("rst_ack", ACK, 0);
        check("rst_ureset", USER_RESET, 0);
        check_active("rst");
        RSTb = 1'b1;

        // ID and unmapped reads
        read_check(0, "id");
        read_check(200, "unmapped_200");
        read_check(1, "control_reads_0");

        // shadow write then SYNC_LOAD commit
        bus_write(16 + 6, 32'hFFFF_1234);
        read_check(144 + 6, "active3_before");
        read_check(3, "pending_set");
        read_check(22, "shadow3");
        @(negedge CLK); SYNC_LOAD = 1'b1;
        @(negedge CLK); SYNC_LOAD = 1'b0; model_commit();
        check("cfg3_active", CH_CONFIG[63:48], 16'h1234);
        check_active("sync_load");
        read_check(3, "pending_clr");

        // held write strobe to CONTROL bit0: one ACK, one PLEN-cycle pulse
        @(negedge CLK);
        ADDR = BASE_A + 18'd1; DATA_IN = 32'h1; CEb = 1'b0; WEb = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            check("held_ack", ACK, (i == 1));
            check("ureset_len", USER_RESET, (i >= 1 && i <= PLEN));
            if (i == 5) begin CEb = 1'b1; WEb = 1'b1; end
        end

        // sticky STATUS, set wins over W1C
        @(negedge CLK); STATUS_IN = 16'h0020;
        @(negedge CLK); STATUS_IN = '0; m_status |= 16'h0020;
        read_check(2, "status_set");
        @(negedge CLK);
        ADDR = BASE_A + 18'd2; DATA_IN = 32'h20; CEb = 1'b0; WEb = 1'b0; STATUS_IN = 16'h0020;
        @(negedge CLK);
        check("w1c_ack", ACK, 1);
        CEb = 1'b1; WEb = 1'b1; STATUS_IN = '0;
        model_write(2, 32'h20); m_status |= 16'h0020;
        read_check(2, "status_set_wins");
        bus_write(2, 32'h20);
        read_check(2, "status_cleared");

        // CONTROL commit path, then shadow write coincident with SYNC_LOAD
        bus_write(17, 32'h123);
        bus_write(1, 32'h2);
        @(negedge CLK);
        check("thr0_commit", CH_THRESHOLD[11:0], 12'h123);
        @(negedge CLK);
        ADDR = BASE_A + 18'd17; DATA_IN = 32'hABC; CEb = 1'b0; WEb = 1'b0; SYNC_LOAD = 1'b1;
        @(negedge CLK);
        check("coinc_ack", ACK, 1);
        CEb = 1'b1; WEb = 1'b1; SYNC_LOAD = 1'b0;
        model_commit(); model_write(17, 32'hABC);
        check("thr0_old_kept", CH_THRESHOLD[11:0], 12'h123);
        check_active("coinc");
        read_check(3, "pending_coinc");
        read_check(17, "thr0_shadow");

        // randomized traffic against the model
        for (int n = 0; n < 120; n++) begin
            int op, off;
            logic [31:0] d;
            op  = $urandom_range(0, 5);
            off = $urandom_range(0, 200);
            d   = $urandom;
            case (op)
                0, 1: begin
                    if (op == 0) off = $urandom_range(16, 16 + 2 * N_CH - 1);
                    if (off == 1) d = d & 32'h2;
                    bus_write(off, d);
                end
                2: begin
                    if ($urandom_range(0, 1) == 1) off = $urandom_range(140, 180);
                    read_check(off, "rnd_read");
                end
                3: begin
                    @(negedge CLK); SYNC_LOAD = 1'b1;
                    @(negedge CLK); SYNC_LOAD = 1'b0; model_commit();
                end
                4: begin
                    @(negedge CLK); STATUS_IN = 16'($urandom);
                    @(negedge CLK); m_status |= STATUS_IN; STATUS_IN = '0;
                end
                default: bus_write(2, d);
            endcase
            check_active("rnd");
            check("rnd_ureset", USER_RESET, 0);
        end
        read_check(2, "rnd_status_final");
        read_check(3, "rnd_pending_final");

        // reset during pulse with a write strobe held across release
        bus_write(16 + 6, 32'h4321);
        bus_write(1, 32'h3);
        read_check(0, "pre_reset_id");
        check("pre_reset_ureset", USER_RESET, 1);
        @(negedge CLK);
        ADDR = BASE_A + 18'd16; DATA_IN = 32'h5555; CEb = 1'b0; WEb = 1'b0; RSTb = 1'b0;
        model_reset();
        #1;
        check("arst_dout", DATA_OUT, 0);
        check("arst_ack", ACK, 0);
        check("arst_ureset", USER_RESET, 0);
        check_active("arst");
        repeat (2) @(negedge CLK);
        RSTb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("held_after_rst_ack", ACK, 0);
        end
        CEb = 1'b1; WEb = 1'b1;
        read_check(16, "no_write_after_rst");
        read_check(3, "pending_after_rst");
        bus_write(16, 32'h7777);
        read_check(16, "write_after_toggle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
